// File: rtl/fetch_line_ctrl_pkg.sv
// Shared frontend definitions: width derivations and the RAS checkpoint layout.
// Latency: none (types and constant functions only).
// Backpressure: none.
package fetch_line_ctrl_pkg;

  // Pointer width for a power-of-two RAS depth (at least one bit)
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Line-counter width once the byte offset is stripped from an address
  function automatic int clc_width(input int xlen, input int offset_bits);
    return xlen - offset_bits;
  endfunction

  // Checkpoint is {tos, count}; count needs one extra bit to hold "full"
  function automatic int ckpt_width(input int depth);
    return 2 * ptr_width(depth) + 1;
  endfunction

  localparam int RAS_DEPTH_DEF = 8;
  localparam int PTR_W_DEF     = ptr_width(RAS_DEPTH_DEF);
  localparam int CKPT_W        = ckpt_width(RAS_DEPTH_DEF);

  // Checkpoint layout shared with the ROB, which stores one per branch
  typedef struct packed {
    logic [PTR_W_DEF-1:0] tos;
    logic [PTR_W_DEF:0]   count;
  } ras_ckpt_t;

endpackage

// File: rtl/fetch_line_ctrl_if.sv
// Bundle of redirect, RAS and fetch-address signals around the fetch controller.
// Latency: none (wires only).
// Backpressure: stall_in is the only hold signal; redirects cannot be refused.
interface fetch_line_ctrl_if
  import fetch_line_ctrl_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int OFFSET_BITS = 4,
  parameter int NUM_SRC     = 3,
  parameter int RAS_DEPTH   = 8
) ();

  localparam int CLC_WIDTH = clc_width(XLEN, OFFSET_BITS);
  localparam int CK_W      = ckpt_width(RAS_DEPTH);

  logic                    stall_in;
  logic [NUM_SRC-1:0]      redir_valid;
  logic [NUM_SRC*XLEN-1:0] redir_target;
  logic                    ras_redirect;
  logic                    ras_push;
  logic                    ras_pop;
  logic [XLEN-1:0]         ras_ret_addr;
  logic                    ras_restore;
  logic [CK_W-1:0]         ras_ckpt_in;
  logic [CK_W-1:0]         ras_ckpt_out;
  logic [CLC_WIDTH-1:0]    clc;
  logic [CLC_WIDTH-1:0]    clc_even;
  logic [CLC_WIDTH-1:0]    clc_odd;
  logic [OFFSET_BITS-1:0]  fetch_offset;
  logic                    fetch_valid;
  logic [XLEN-1:0]         ras_data_out;
  logic                    ras_valid_out;

  modport master (
    output stall_in, redir_valid, redir_target, ras_redirect, ras_push, ras_pop,
           ras_ret_addr, ras_restore, ras_ckpt_in,
    input  ras_ckpt_out, clc, clc_even, clc_odd, fetch_offset, fetch_valid,
           ras_data_out, ras_valid_out
  );

  modport slave (
    input  stall_in, redir_valid, redir_target, ras_redirect, ras_push, ras_pop,
           ras_ret_addr, ras_restore, ras_ckpt_in,
    output ras_ckpt_out, clc, clc_even, clc_odd, fetch_offset, fetch_valid,
           ras_data_out, ras_valid_out
  );

endinterface

// File: rtl/fetch_line_ctrl_ras_circ.sv
// Circular return-address stack with wrap-on-overflow and checkpoint restore.
// Latency: push/pop/restore visible one cycle after the sampling edge; top is combinational.
// Backpressure: none; a push when full overwrites the oldest entry, a pop when empty is dropped.
module ras_circ
  import fetch_line_ctrl_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic                             pop,
  input  logic [XLEN-1:0]                  ret_addr,
  input  logic                             restore,
  input  logic [ckpt_width(RAS_DEPTH)-1:0] ckpt_in,
  output logic [ckpt_width(RAS_DEPTH)-1:0] ckpt_out,
  output logic [XLEN-1:0]                  data_out,
  output logic                             valid_out
);

  localparam int PTR_W = ptr_width(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CK_W  = ckpt_width(RAS_DEPTH);

  logic [PTR_W-1:0] tos;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  entry [RAS_DEPTH];

  logic [PTR_W-1:0] tos_inc;
  logic             nonempty;
  logic             full;
  logic             replace_top;

  assign tos_inc  = tos + PTR_W'(1);
  assign nonempty = (count != '0);
  assign full     = (count == CNT_W'(RAS_DEPTH));
  // Push and pop together on a non-empty stack rewrites the top in place;
  // on an empty stack there is nothing to replace, so it is a plain push.
  assign replace_top = push && pop && nonempty;

  // Pointer update; a restore wins over any push/pop in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tos   <= '0;
      count <= '0;
    end else if (restore) begin
      tos   <= ckpt_in[CK_W-1 -: PTR_W];
      count <= ckpt_in[CNT_W-1:0];
    end else if (push && !replace_top) begin
      tos <= tos_inc;
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !push && nonempty) begin
      tos   <= tos - PTR_W'(1);
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage carries no reset; count gates whether contents are meaningful
  always_ff @(posedge clk) begin
    if (!restore && push) begin
      if (replace_top) entry[tos] <= ret_addr;
      else             entry[tos_inc] <= ret_addr;
    end
  end

  assign data_out  = entry[tos];
  assign valid_out = nonempty;
  assign ckpt_out  = {tos, count};

endmodule

// File: rtl/fetch_line_ctrl.sv
// Fetch line controller: prioritised redirect, line counter and even/odd bank addresses.
// Latency: redirect/advance visible one cycle after the sampling edge; bank addresses combinational.
// Backpressure: stall_in holds the line counter; redirects always win and are never dropped.
module fetch_line_ctrl
  import fetch_line_ctrl_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              OFFSET_BITS = 4,
  parameter int              NUM_SRC     = 3,
  parameter int              RAS_DEPTH   = 8,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input logic             clk,
  input logic             rst,
  fetch_line_ctrl_if.slave bus
);

  localparam int CLC_WIDTH = clc_width(XLEN, OFFSET_BITS);

  logic                   started;
  logic                   redir_sel;
  logic [XLEN-1:0]        redir_tgt;
  logic [CLC_WIDTH-1:0]   clc_q;
  logic [CLC_WIDTH-1:0]   clc_inc;
  logic [OFFSET_BITS-1:0] offset_q;
  logic [XLEN-1:0]        ras_top;
  logic                   ras_nonempty;

  ras_circ #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.ras_push),
    .pop       (bus.ras_pop),
    .ret_addr  (bus.ras_ret_addr),
    .restore   (bus.ras_restore),
    .ckpt_in   (bus.ras_ckpt_in),
    .ckpt_out  (bus.ras_ckpt_out),
    .data_out  (ras_top),
    .valid_out (ras_nonempty)
  );

  // Redirect winner: lowest-index valid source, else a return prediction from a non-empty RAS.
  // The RAS top read here is the pre-pop value, so a same-cycle pop does not disturb it.
  always_comb begin
    redir_sel = 1'b0;
    redir_tgt = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (bus.redir_valid[i]) begin
        redir_sel = 1'b1;
        redir_tgt = bus.redir_target[i*XLEN +: XLEN];
      end
    end
    if (!redir_sel && bus.ras_redirect && ras_nonempty) begin
      redir_sel = 1'b1;
      redir_tgt = ras_top;
    end
  end

  // Started flag: fetch output becomes valid from the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) started <= 1'b0;
    else     started <= 1'b1;
  end

  // Line counter: redirect beats stall; the reset line is held until it has been fetched once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clc_q    <= RESET_PC[XLEN-1:OFFSET_BITS];
      offset_q <= RESET_PC[OFFSET_BITS-1:0];
    end else if (redir_sel) begin
      clc_q    <= redir_tgt[XLEN-1:OFFSET_BITS];
      offset_q <= redir_tgt[OFFSET_BITS-1:0];
    end else if (started && !bus.stall_in) begin
      clc_q    <= clc_inc;
      offset_q <= '0;
    end
  end

  assign clc_inc          = clc_q + CLC_WIDTH'(1);
  assign bus.clc          = clc_q;
  assign bus.fetch_offset = offset_q;
  assign bus.clc_even     = clc_q[0] ? clc_inc : clc_q;
  assign bus.clc_odd      = clc_q[0] ? clc_q : clc_inc;
  assign bus.fetch_valid  = started & ~bus.stall_in;
  assign bus.ras_data_out = ras_top;
  assign bus.ras_valid_out = ras_nonempty;

endmodule

// File: doc/fetch_line_ctrl.md
Name: fetch_line_ctrl

Overview:
Parametrised frontend fetch controller that generates the current cacheline counter (CLC) and the even/odd bank line addresses for the I-cache each cycle. It adds four things over the prior fetch control:
- N-source prioritised redirect.
- Configurable line size.
- A circular return-address stack (RAS) with overflow wrap.
- ROB-driven RAS checkpoint restore.

It sits between the branch/ROB redirect logic and the I-cache tag/data banks.

Parameters:
XLEN, 32, address width
OFFSET_BITS, 4, log2 of line bytes; localparam CLC_WIDTH = XLEN-OFFSET_BITS
NUM_SRC, 3, redirect sources; index 0 = highest priority (ROB, then D1, then BR)
RAS_DEPTH, 8, RAS entries (power of 2); localparam PTR_W = log2(RAS_DEPTH)
RESET_PC, 0, fetch address loaded at reset

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
stall_in  in  1  hold CLC (no advance)
redir_valid  in  NUM_SRC  per-source redirect request
redir_target  in  NUM_SRC*XLEN  packed targets; source i at [i*XLEN +: XLEN]
ras_redirect  in  1  redirect to RAS top (return prediction)
ras_push  in  1  push ras_ret_addr
ras_pop  in  1  pop top
ras_ret_addr  in  XLEN  return address to push
ras_restore  in  1  restore RAS pointers from checkpoint
ras_ckpt_in  in  PTR_W+PTR_W+1  {tos, count} checkpoint to restore
ras_ckpt_out  out  PTR_W+PTR_W+1  current {tos, count}
clc  out  CLC_WIDTH  current line counter
clc_even  out  CLC_WIDTH  even-bank line address
clc_odd  out  CLC_WIDTH  odd-bank line address
fetch_offset  out  OFFSET_BITS  starting byte offset in the current line
fetch_valid  out  1  fetch address valid this cycle
ras_data_out  out  XLEN  RAS top entry
ras_valid_out  out  1  RAS non-empty

Behaviour:
Reset values (asynchronous):
- clc = RESET_PC[XLEN-1:OFFSET_BITS]; fetch_offset = RESET_PC[OFFSET_BITS-1:0].
- fetch_valid = 0; RAS tos = 0, count = 0; RAS entry storage not reset.
- fetch_valid rises the first clk edge after rst deasserts; thereafter fetch_valid = ~stall_in, combinational on a registered started flag.

Redirect selection (combinational):
- Winner is the lowest index i with redir_valid[i]; target = that source's slice.
- Else, if ras_redirect && ras_valid_out, target = ras_data_out, sampled before any same-cycle pop.
- ras_redirect while the RAS is empty is ignored.

CLC update, per clk edge, first match wins:
1. A redirect is selected: clc = target[XLEN-1:OFFSET_BITS], fetch_offset = target[OFFSET_BITS-1:0]. Redirect overrides stall_in and is never dropped.
2. stall_in: hold clc and fetch_offset.
3. Otherwise: clc = clc+1, wrapping modulo 2^CLC_WIDTH; fetch_offset = 0.

Even/odd line addresses (combinational from clc):
- clc[0] == 0: clc_even = clc, clc_odd = clc+1.
- clc[0] == 1: clc_odd = clc, clc_even = clc+1.
- The +1 wraps modulo 2^CLC_WIDTH, so all-ones maps to 0.

RAS (circular):
- Push: tos = tos+1 (mod depth), write entry[tos+1], count = min(count+1, RAS_DEPTH). A push when full overwrites the oldest entry.
- Pop: if count > 0, tos = tos-1, count = count-1. A pop when empty is a no-op.
- Push and pop together: overwrite entry[tos], pointers unchanged. If the RAS is empty, this behaves as a plain push.
- ras_restore: load {tos, count} from ras_ckpt_in and ignore push/pop that cycle. Entry storage is untouched.
- ras_data_out = entry[tos]; ras_valid_out = (count != 0).
- ras_ckpt_out is the registered {tos, count}.
- RAS operations are independent of stall_in.

Latency: CLC and RAS state both take effect 1 cycle after the sampling edge.

Decomposition:
- Shared frontend package holds the PTR_W/CLC_WIDTH derivation function and the checkpoint struct/width constant, so the ROB uses the same layout.
- One sub-module: ras_circ, holding the circular RAS storage, pointers and checkpoint logic.
- Redirect priority mux and CLC register stay in the top.

Test Plan:
1. Reset release with RESET_PC=0x1008 → clc=0x100, fetch_offset=8, clc_even=0x100, clc_odd=0x101, fetch_valid 0 then 1. Next cycle: clc=0x101, offset=0, clc_even=0x102, clc_odd=0x101.
2. Priority: redir_valid=3'b110 with D1=0x2000 and BR=0x3000 → clc=0x200. Then redir_valid=3'b111 with ROB=0x4004 → clc=0x400, offset=4.
3. Stall vs redirect: stall_in=1 for 3 cycles → clc holds, fetch_valid=0. During the stall, BR redirect to 0x5000 → clc=0x500 and still held while stalled.
4. RAS overflow (depth 8): push 0x100..0x900 (9 pushes) → count=8, top=0x900. Eight pops return 0x900..0x200, then ras_valid_out=0. A ninth pop is a no-op.
5. RAS checkpoint: push A, B; save ckpt; push C, pop, pop; assert ras_restore with the saved ckpt → ras_data_out=B, count=2.
6. Wrap and RAS redirect: clc=0xFFFFFFF, clc_even=0x0, clc_odd=0xFFFFFFF. Next cycle clc=0x0. With top=0x8010, ras_redirect plus a same-cycle pop → clc=0x801, count decremented.
